// File: rtl/ex_div_seq.sv
// Iterative RV32M divide/remainder unit for the execute stage.
// It uses restoring division on operand magnitudes, one quotient bit per cycle, and applies sign correction on exit.
module ex_div_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [1:0]      divop_i,
  input  logic [XLEN-1:0] opr_a_i,
  input  logic [XLEN-1:0] opr_b_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic            res_valid_o,
  output logic [XLEN-1:0] res_o
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state_q, state_d;
  logic            rem_sel_q;
  logic            neg_quo_q, neg_rem_q;
  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] b_q, rem_q, quo_q, res_q;

  logic            is_signed, div_zero, sign_ovf, accept;
  logic [XLEN-1:0] abs_a, abs_b, quo_fix, rem_fix, result;
  logic [XLEN:0]   trial;

  always_comb begin
    is_signed = ~divop_i[0];
    abs_a     = (is_signed && opr_a_i[XLEN-1]) ? -opr_a_i : opr_a_i;
    abs_b     = (is_signed && opr_b_i[XLEN-1]) ? -opr_b_i : opr_b_i;
    div_zero  = (opr_b_i == '0);
    sign_ovf  = is_signed && (opr_a_i == {1'b1, {(XLEN-1){1'b0}}}) && (opr_b_i == '1);
    accept    = (state_q == IDLE) && start_i && !flush_i;
    // 33-bit subtract: the shifted partial remainder can exceed XLEN bits
    trial     = {rem_q, quo_q[XLEN-1]} - {1'b0, b_q};
    quo_fix   = neg_quo_q ? -quo_q : quo_q;
    rem_fix   = neg_rem_q ? -rem_q : rem_q;
    result    = rem_sel_q ? rem_fix : quo_fix;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = (div_zero || sign_ovf) ? DONE : CALC;
      CALC: if (cnt_q == '0) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush_i) state_d = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_sel_q <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      cnt_q     <= '0;
      b_q       <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      res_q     <= '0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          rem_sel_q <= divop_i[1];
          b_q       <= abs_b;
          cnt_q     <= CW'(XLEN - 1);
          // Special cases preload the final value, so no sign fix-up is applied
          if (div_zero) begin
            quo_q     <= '1;
            rem_q     <= opr_a_i;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
          end else if (sign_ovf) begin
            quo_q     <= {1'b1, {(XLEN-1){1'b0}}};
            rem_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
          end else begin
            quo_q     <= abs_a;
            rem_q     <= '0;
            neg_quo_q <= is_signed && (opr_a_i[XLEN-1] ^ opr_b_i[XLEN-1]);
            neg_rem_q <= is_signed && opr_a_i[XLEN-1];
          end
        end
        CALC: if (!flush_i) begin
          rem_q <= trial[XLEN] ? {rem_q[XLEN-2:0], quo_q[XLEN-1]} : trial[XLEN-1:0];
          quo_q <= {quo_q[XLEN-2:0], ~trial[XLEN]};
          cnt_q <= cnt_q - CW'(1);
        end
        DONE: if (!flush_i) res_q <= result;
        default: ;
      endcase
    end
  end

  always_comb begin
    stall_o     = accept || ((state_q == CALC) && !flush_i);
    res_valid_o = (state_q == DONE) && !flush_i;
    res_o       = res_valid_o ? result : res_q;
  end

endmodule
